aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//   Iterative AES-128 key schedule feeding the round datapath, up to and including the final
//   SubBytes/ShiftRows/AddRoundKey stage. Latches a 128-bit cipher key and streams round keys
//   0..NR over a valid/ready handshake, one key per accepted transfer.
//   Each key is derived on the fly from the previous one; only one 128-bit key is stored.
// PARAMETERS
//   NR  10  number of round keys after round key 0; legal 1..10, limited by the Rcon table
// PORTS
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    request expansion of cipher_key; honoured only in IDLE
//   cipher_key  in   128  key, byte 0 at [127:120], column-major
//   busy        out  1    high while in state EMIT
//   rk_valid    out  1    round_key/round_idx are valid
//   rk_ready    in   1    consumer accepts the current round key
//   round_idx   out  4    index of the current round_key, 0..NR
//   round_key   out  128  round key, same byte packing as cipher_key
//   done        out  1    one-cycle pulse after round key NR is accepted
// BEHAVIOUR
//   Reset: asynchronous on rst_n low. State returns to IDLE. busy=0, rk_valid=0, round_idx=0,
//     round_key=0, done=0. An expansion in progress is abandoned; no partial done is issued.
//   States: IDLE, EMIT.
//   IDLE: busy=0, rk_valid=0.
//     - start=1 at a clock edge: register cipher_key into round_key, set round_idx=0, go to EMIT.
//     - The first valid key is therefore visible 1 cycle after start.
//   EMIT: busy=1, rk_valid=1.
//     - Transfer occurs when rk_valid && rk_ready are both high at a clock edge.
//     - Transfer with round_idx<NR: round_key <= next(round_key, rcon[round_idx+1]);
//       round_idx increments by 1. Sustained throughput is one key per cycle.
//     - Transfer with round_idx==NR: go to IDLE, and done=1 for exactly the next cycle.
//     - rk_ready=0: round_key and round_idx hold stable (no drop, no duplicate).
//   next(): words w0..w3 with w0=[127:96].
//     - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
//     - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
//     - RotWord is a 1-byte left rotate. SubWord uses the 4 S-box instances from the shared
//       subBytes table.
//   Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
//   Simultaneous events:
//     - start while busy is ignored, and cipher_key is not sampled.
//     - start in the done cycle is accepted, because the state is IDLE in that cycle.
//   Once a key is latched, cipher_key may change freely without affecting the expansion.
//   Fully synchronous datapath; no combinational path from rk_ready to rk_valid or round_key.
// TESTING
//   1. FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
//      -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605;
//      -> idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done exactly 12 cycles after start.
//   2. All-zero key -> idx1 = 62636363626363636263636362636363, idx2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
//   3. Random rk_ready back-pressure on vector 1.
//      -> keys are identical to scenario 1 and in order; outputs are stable while stalled.
//   4. rst_n pulsed low at idx5 -> all outputs 0 immediately; a following start restarts at idx0.
//   5. start while busy with a different key -> ignored; start in the done cycle -> new idx0 next cycle.
//   6. NR=1 build -> exactly 2 transfers (idx0, idx1), then done.

Source files
------------

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: latches a cipher key and streams round keys 0..NR
// over a valid/ready handshake, deriving each key from the single stored previous key.
module aes_key_expander #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 32;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t state, state_d;

  logic [KEY_W-1:0]  key_d;
  logic [IDX_W-1:0]  idx_d;
  logic              done_d;
  logic              emit_d;
  logic [KEY_W-1:0]  next_key;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One key-schedule step from the currently presented key.
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w, sub_w, t_w;
  logic [WORD_W-1:0] nw0, nw1, nw2, nw3;

  assign w0    = round_key[127:96];
  assign w1    = round_key[95:64];
  assign w2    = round_key[63:32];
  assign w3    = round_key[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign sub_w[8*g +: 8] = sbox(rot_w[8*g +: 8]);
  end

  assign t_w      = sub_w ^ {rcon(round_idx + IDX_W'(1)), 24'h000000};
  assign nw0      = w0 ^ t_w;
  assign nw1      = w1 ^ nw0;
  assign nw2      = w2 ^ nw1;
  assign nw3      = w3 ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      round_idx <= '0;
      round_key <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= emit_d;
      rk_valid  <= emit_d;
      round_idx <= idx_d;
      round_key <= key_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    key_d   = round_key;
    idx_d   = round_idx;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_d   = cipher_key;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_idx == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = round_idx + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    emit_d = (state_d == EMIT);
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors, back-pressure, reset,
// start collisions and a single-round build.
module tb_aes_key_expander;

  localparam int unsigned NR = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         done;

  logic         start_b;
  logic [127:0] key_b;
  logic         busy_b;
  logic         valid_b;
  logic         ready_b;
  logic [3:0]   idx_b;
  logic [127:0] rkey_b;
  logic         done_b;

  aes_key_expander #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cipher_key(cipher_key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .round_idx(round_idx), .round_key(round_key), .done(done)
  );

  aes_key_expander #(.NR(1)) dut_nr1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cipher_key(key_b),
    .busy(busy_b), .rk_valid(valid_b), .rk_ready(ready_b),
    .round_idx(idx_b), .round_key(rkey_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           set;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  int           total = 0;
  int           bad   = 0;
  logic [127:0] fips [11];
  logic [127:0] captured [3][11];
  vec_t         vecs [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Run one full expansion on the NR=10 instance, capturing each transferred key.
  task automatic expand(input logic [127:0] key, input int set, input bit bp);
    int           cyc;
    int           n;
    bit           fin;
    bit           stalled;
    logic [127:0] hold_key;
    logic [3:0]   hold_idx;
    @(negedge clk);
    start = 1'b1; cipher_key = key; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cipher_key = ~key;
    cyc = 1; n = 0; fin = 1'b0; stalled = 1'b0;
    hold_key = '0; hold_idx = '0;
    while (!fin && cyc < 400) begin
      if (done) begin
        fin = 1'b1;
        check("done_idle", {126'd0, busy, rk_valid}, 128'd0);
        if (!bp) check("done_latency", 128'(cyc), 128'd12);
      end else begin
        if (stalled) begin
          check("stall_key", round_key, hold_key);
          check("stall_idx", 128'(round_idx), 128'(hold_idx));
        end
        rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled  = rk_valid && !rk_ready;
        hold_key = round_key;
        hold_idx = round_idx;
        if (rk_valid && rk_ready) begin
          check("order_idx", 128'(round_idx), 128'(n));
          if (n < 11) captured[set][n] = round_key;
          n++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 128'(fin), 128'd1);
    check("transfer_count", 128'(n), 128'(NR + 1));
    rk_ready = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 40) begin
      @(negedge clk);
      i++;
    end
    check(name, 128'(done), 128'd1);
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) begin
      vecs.push_back('{set: 0, idx: i, exp: fips[i]});
      vecs.push_back('{set: 2, idx: i, exp: fips[i]});
    end
    vecs.push_back('{set: 1, idx: 0, exp: 128'h0});
    vecs.push_back('{set: 1, idx: 1, exp: 128'h62636363626363636263636362636363});
    vecs.push_back('{set: 1, idx: 2, exp: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 11; i++) captured[s][i] = '0;

    start = 1'b0; cipher_key = '0; rk_ready = 1'b0;
    start_b = 1'b0; key_b = '0; ready_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_key", round_key, 128'd0);
    check("reset_flags", {119'd0, busy, rk_valid, done, round_idx}, 128'd0);
    rst_n = 1'b1;

    // Full expansions: FIPS key, zero key, FIPS key under back-pressure.
    expand(fips[0], 0, 1'b0);
    expand(128'h0, 1, 1'b0);
    expand(fips[0], 2, 1'b1);
    foreach (vecs[k])
      check($sformatf("key_set%0d_idx%0d", vecs[k].set, vecs[k].idx),
            captured[vecs[k].set][vecs[k].idx], vecs[k].exp);

    // Reset in the middle of an expansion, then restart.
    @(negedge clk);
    start = 1'b1; cipher_key = fips[0]; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) @(negedge clk);
    check("reach_idx5", 128'(round_idx), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_key", round_key, 128'd0);
    check("rst_mid_flags", {119'd0, busy, rk_valid, done, round_idx}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_done", {126'd0, done, busy}, 128'd0);
    start = 1'b1; cipher_key = fips[0];
    @(negedge clk);
    start = 1'b0;
    check("restart_idx0", 128'(round_idx), 128'd0);
    check("restart_key0", round_key, fips[0]);
    check("restart_valid", 128'(rk_valid), 128'd1);
    wait_done("restart_done");

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; cipher_key = fips[0];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; cipher_key = 128'h0;
    @(negedge clk);
    start = 1'b0; cipher_key = 128'hffff;
    check("busy_start_idx", 128'(round_idx), 128'd2);
    check("busy_start_key", round_key, fips[2]);
    wait_done("collide_done");
    check("done_cycle_busy", 128'(busy), 128'd0);
    start = 1'b1; cipher_key = 128'h0;
    @(negedge clk);
    start = 1'b0;
    check("done_start_valid", 128'(rk_valid), 128'd1);
    check("done_start_idx", 128'(round_idx), 128'd0);
    check("done_start_key", round_key, 128'd0);
    @(negedge clk);
    check("done_start_key1", round_key, 128'h62636363626363636263636362636363);
    wait_done("second_done");

    // Single-round build: exactly idx0 and idx1, then done.
    begin
      int           n;
      int           cyc;
      logic [127:0] got [2];
      got[0] = '0; got[1] = '0;
      @(negedge clk);
      start_b = 1'b1; key_b = fips[0]; ready_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      n = 0; cyc = 1;
      while (!done_b && cyc < 20) begin
        if (valid_b && ready_b) begin
          if (n < 2) got[n] = rkey_b;
          n++;
        end
        @(negedge clk);
        cyc++;
      end
      check("nr1_transfers", 128'(n), 128'd2);
      check("nr1_done_latency", 128'(cyc), 128'd3);
      check("nr1_key0", got[0], fips[0]);
      check("nr1_key1", got[1], fips[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
